fifo_access_ctrl: RTL and testbench
===================================

# fifo_access_ctrl

Controller that sequences the shared 8-bit FIFO on both sides. On the write side it round-robin arbitrates two producers onto the FIFO write port and holds off while the FIFO is full. On the read side it pops one word per consumer request, runs it through the binary-to-BCD converter with a start/done handshake, and latches the result for the hex display mux. It sits between the debounced button/producer logic and the fifo, bin2bcd and display units.

## Interface
- DATA_W, 8: FIFO word width.
- TIMEOUT, 64: maximum cycles to wait for `cvt_done` before aborting. Must be ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1  write requests (levels). A requester holds `reqN` and `dataN` until it sees `gntN` at a clock edge.
- data0, data1  in  DATA_W  write data for each requester.
- gnt0, gnt1  out  1  combinational grant; high in the cycle the word is written.
- rd_req  in  1  single-cycle pop request from the consumer.
- fifo_full, fifo_empty  in  1  FIFO status.
- fifo_rd_data  in  DATA_W  FIFO head word (show-ahead).
- fifo_wr  out  1  FIFO write strobe (combinational).
- fifo_wr_data  out  DATA_W  mux of data0/data1 per grant; 0 when no grant.
- fifo_rd  out  1  FIFO pop strobe (registered state decode).
- cvt_start  out  1  one-cycle start pulse to bin2bcd.
- cvt_bin  out  DATA_W  word under conversion (hold register).
- cvt_done  in  1  bin2bcd completion tick.
- disp_val  out  DATA_W  last successfully converted word.
- disp_valid  out  1  high once any conversion has completed; sticky until reset.
- busy  out  1  read sequencer not in IDLE.
- rd_err  out  1  one-cycle pulse: request rejected, or conversion timed out.

## Operation
- Write arbiter:
  - `fifo_wr = !fifo_full & (req0 | req1)`.
  - If only one request is pending, that requester is granted.
  - If both are pending, the requester not granted last wins.
  - `last` pointer updates on each grant. Reset value is `last=1`, so req0 wins the first tie.
  - Exactly one `gntN` may be high in a cycle, and only together with `fifo_wr`.
  - While `fifo_full`, no grant is issued and `last` does not change.
- Read FSM states: IDLE, POP, CONV, WAIT.
  - IDLE: `rd_req & !fifo_empty` → capture `fifo_rd_data` into the hold register, go to POP. `rd_req & fifo_empty` → `rd_err` pulse, stay in IDLE.
  - POP: `fifo_rd=1` for exactly one cycle → CONV.
  - CONV: `cvt_start=1` for exactly one cycle, `cvt_bin` = hold register, clear the timeout counter → WAIT.
  - WAIT: on `cvt_done`, `disp_val` ← hold register, `disp_valid` ← 1, go to IDLE. If the counter reaches TIMEOUT-1 without `cvt_done`, raise `rd_err`, go to IDLE, and leave `disp_val` unchanged.
  - `rd_req` in any state other than IDLE is dropped and pulses `rd_err`.
  - `cvt_done` outside WAIT is ignored.
- The write and read sides are independent. `fifo_wr` and `fifo_rd` may be high in the same cycle; the FIFO handles simultaneous read and write.
- The FIFO is read only by this block, so the emptiness check made in IDLE still holds in POP.

## Timing
- Reset (asynchronous, any state):
  - FSM → IDLE, `last=1`, timeout counter = 0.
  - `disp_val=0`, `disp_valid=0`, `cvt_bin=0`, `rd_err=0`, `fifo_rd=0`, `cvt_start=0`, `busy=0`.
  - Combinational outputs follow their inputs immediately.
  - A reset during POP, CONV or WAIT abandons the word in flight. If reset hits in POP, the pop may not have taken effect.
- Write latency: 0 cycles; the grant and write happen in the request cycle. A requester with uncontested access to a non-full FIFO can write one word per cycle.
- Read latency for `rd_req` in cycle 0:
  - `fifo_rd` in cycle 1, `cvt_start` in cycle 2.
  - `cvt_done` sampled in cycle k ≥ 3 → `disp_val`/`disp_valid` updated at the end of cycle k.
  - FSM is back in IDLE at cycle k+1, and a new `rd_req` is accepted from cycle k+1.
- `busy` is high in cycles 1..k inclusive.
- `rd_err` is registered and appears one cycle after its cause.

## Test plan
1. Reset mid-WAIT with `disp_val=0x2A`: all registered outputs go to 0 immediately, FSM is in IDLE, and `req0` wins the first tie afterwards.
2. `req0` and `req1` held for 4 cycles, FIFO not full, data0=0x11, data1=0x22: FIFO receives 0x11, 0x22, 0x11, 0x22, and grants alternate gnt0, gnt1, gnt0, gnt1.
3. `fifo_full=1` with `req1` high for 3 cycles, then full drops: no `fifo_wr` and no `gnt1` while full; `gnt1` and `fifo_wr` occur in the first non-full cycle.
4. FIFO head 0x9F, `rd_req` in cycle 0, `cvt_done` in cycle 5: `fifo_rd` in cycle 1, `cvt_start` in cycle 2 with `cvt_bin=0x9F`, `disp_val=0x9F` and `disp_valid=1` from cycle 6.
5. `rd_req` while `fifo_empty`, and a second `rd_req` during WAIT: each produces one `rd_err` pulse, with no `fifo_rd` and no state change.
6. `cvt_done` never arrives, TIMEOUT=64: `rd_err` one cycle after WAIT cycle 63, FSM in IDLE, `disp_val` unchanged; simultaneous writes continue unaffected.

Source files
------------

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: shared FIFO sequencer.
// Write side: round-robin arbiter for two producers onto the FIFO write port.
// Read side: pop one word per consumer request, hand it to bin2bcd with a
// start/done handshake, and keep the last converted word for the display mux.
module fifo_access_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              rd_req,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              fifo_rd,
    output logic              cvt_start,
    output logic [DATA_W-1:0] cvt_bin,
    input  logic              cvt_done,
    output logic [DATA_W-1:0] disp_val,
    output logic              disp_valid,
    output logic              busy,
    output logic              rd_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_CONV,
        S_WAIT
    } state_e;

    // Write arbiter state: 1 means requester 1 was granted most recently.
    logic last_q;
    logic last_d;
    logic pick0;

    // Read sequencer state and registered outputs.
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] disp_val_q;
    logic              disp_valid_q;
    logic              fifo_rd_q;
    logic              cvt_start_q;
    logic              busy_q;
    logic              rd_err_q;

    // Combinational round-robin grant; requester 0 wins a tie when 1 was last.
    always_comb begin
        fifo_wr      = !fifo_full && (req0 || req1);
        pick0        = req0 && (!req1 || last_q);
        gnt0         = fifo_wr && pick0;
        gnt1         = fifo_wr && !pick0;
        fifo_wr_data = '0;
        if (gnt0) begin
            fifo_wr_data = data0;
        end else if (gnt1) begin
            fifo_wr_data = data1;
        end
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    // Last-grant pointer; frozen while full because no grant is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // Read sequencer: IDLE -> POP -> CONV -> WAIT -> IDLE, with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            disp_val_q   <= '0;
            disp_valid_q <= 1'b0;
            fifo_rd_q    <= 1'b0;
            cvt_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            fifo_rd_q   <= 1'b0;
            cvt_start_q <= 1'b0;
            rd_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_req) begin
                        if (fifo_empty) begin
                            rd_err_q <= 1'b1;
                        end else begin
                            hold_q    <= fifo_rd_data;
                            fifo_rd_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_POP;
                        end
                    end
                end
                S_POP: begin
                    cvt_start_q <= 1'b1;
                    state_q     <= S_CONV;
                end
                S_CONV: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cvt_done) begin
                        disp_val_q   <= hold_q;
                        disp_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        rd_err_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
            if (rd_req && (state_q != S_IDLE)) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    assign fifo_rd    = fifo_rd_q;
    assign cvt_start  = cvt_start_q;
    assign cvt_bin    = hold_q;
    assign disp_val   = disp_val_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed bench for fifo_access_ctrl: write arbiter vector table plus
// hand-written read-sequencer scenarios (latency, errors, timeout, reset).
module tb_fifo_access_ctrl;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1;
    logic       rd_req;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_wr;
    logic [7:0] fifo_wr_data;
    logic       fifo_rd;
    logic       cvt_start;
    logic [7:0] cvt_bin;
    logic       cvt_done;
    logic [7:0] disp_val;
    logic       disp_valid;
    logic       busy;
    logic       rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_access_ctrl #(.DATA_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd_req(rd_req), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data), .fifo_rd(fifo_rd),
        .cvt_start(cvt_start), .cvt_bin(cvt_bin), .cvt_done(cvt_done),
        .disp_val(disp_val), .disp_valid(disp_valid),
        .busy(busy), .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r0, r1, full;
        logic [7:0] d0, d1;
        logic       wr, g0, g1;
        logic [7:0] wd;
    } wvec_t;

    wvec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Start of a cycle: just after the rising edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, " disp_val"},   32'(disp_val),   32'h0);
        chk({tag, " disp_valid"}, 32'(disp_valid), 32'h0);
        chk({tag, " cvt_bin"},    32'(cvt_bin),    32'h0);
        chk({tag, " rd_err"},     32'(rd_err),     32'h0);
        chk({tag, " fifo_rd"},    32'(fifo_rd),    32'h0);
        chk({tag, " cvt_start"},  32'(cvt_start),  32'h0);
        chk({tag, " busy"},       32'(busy),       32'h0);
    endtask

    initial begin
        // r0 r1 full d0 d1 -> wr g0 g1 wd ; pointer starts at last=1
        vt[0]  = '{1, 1, 0, 8'h11, 8'h22, 1, 1, 0, 8'h11};
        vt[1]  = '{1, 1, 0, 8'h11, 8'h22, 1, 0, 1, 8'h22};
        vt[2]  = '{1, 1, 0, 8'h11, 8'h22, 1, 1, 0, 8'h11};
        vt[3]  = '{1, 1, 0, 8'h11, 8'h22, 1, 0, 1, 8'h22};
        vt[4]  = '{0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00};
        vt[5]  = '{0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00};
        vt[6]  = '{0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00};
        vt[7]  = '{0, 1, 0, 8'h11, 8'h22, 1, 0, 1, 8'h22};
        vt[8]  = '{1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00};
        vt[9]  = '{1, 1, 0, 8'h11, 8'h22, 1, 1, 0, 8'h11};
        vt[10] = '{1, 0, 0, 8'hA5, 8'h22, 1, 1, 0, 8'hA5};
        vt[11] = '{1, 1, 0, 8'hA5, 8'h3C, 1, 0, 1, 8'h3C};
        vt[12] = '{0, 0, 0, 8'hA5, 8'h3C, 0, 0, 0, 8'h00};
        vt[13] = '{1, 0, 0, 8'h01, 8'h3C, 1, 1, 0, 8'h01};

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        rd_req = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
        fifo_rd_data = '0; cvt_done = 1'b0;

        // Reset state
        mid; mid;
        chk_regs_zero("reset");
        next_cycle;
        reset = 1'b0;

        // Write arbiter table
        for (int i = 0; i < 14; i++) begin
            next_cycle;
            req0 = vt[i].r0; req1 = vt[i].r1; fifo_full = vt[i].full;
            data0 = vt[i].d0; data1 = vt[i].d1;
            mid;
            chk($sformatf("wv%0d fifo_wr", i), 32'(fifo_wr), 32'(vt[i].wr));
            chk($sformatf("wv%0d gnt0", i), 32'(gnt0), 32'(vt[i].g0));
            chk($sformatf("wv%0d gnt1", i), 32'(gnt1), 32'(vt[i].g1));
            chk($sformatf("wv%0d wr_data", i), 32'(fifo_wr_data), 32'(vt[i].wd));
            chk($sformatf("wv%0d busy", i), 32'(busy), 32'h0);
        end
        next_cycle;
        req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0;

        // Read latency: head 0x9F, rd_req in cycle 0, cvt_done in cycle 5
        fifo_empty = 1'b0; fifo_rd_data = 8'h9F; rd_req = 1'b1;
        mid;
        chk("rd c0 busy", 32'(busy), 32'h0);
        next_cycle; rd_req = 1'b0; fifo_rd_data = 8'h33;
        mid;
        chk("rd c1 fifo_rd", 32'(fifo_rd), 32'h1);
        chk("rd c1 busy", 32'(busy), 32'h1);
        chk("rd c1 cvt_start", 32'(cvt_start), 32'h0);
        next_cycle; mid;
        chk("rd c2 cvt_start", 32'(cvt_start), 32'h1);
        chk("rd c2 cvt_bin", 32'(cvt_bin), 32'h9F);
        chk("rd c2 fifo_rd", 32'(fifo_rd), 32'h0);
        next_cycle; mid;
        chk("rd c3 cvt_start", 32'(cvt_start), 32'h0);
        next_cycle; mid;
        chk("rd c4 busy", 32'(busy), 32'h1);
        next_cycle; cvt_done = 1'b1;
        mid;
        chk("rd c5 busy", 32'(busy), 32'h1);
        chk("rd c5 disp_valid", 32'(disp_valid), 32'h0);
        next_cycle; cvt_done = 1'b0;
        mid;
        chk("rd c6 disp_val", 32'(disp_val), 32'h9F);
        chk("rd c6 disp_valid", 32'(disp_valid), 32'h1);
        chk("rd c6 busy", 32'(busy), 32'h0);
        chk("rd c6 rd_err", 32'(rd_err), 32'h0);

        // rd_req while empty
        next_cycle; fifo_empty = 1'b1; rd_req = 1'b1;
        next_cycle; rd_req = 1'b0;
        mid;
        chk("empty rd_err", 32'(rd_err), 32'h1);
        chk("empty fifo_rd", 32'(fifo_rd), 32'h0);
        chk("empty busy", 32'(busy), 32'h0);
        next_cycle; mid;
        chk("empty rd_err clr", 32'(rd_err), 32'h0);

        // rd_req during WAIT is dropped with one error pulse
        fifo_empty = 1'b0; fifo_rd_data = 8'h2A; rd_req = 1'b1;
        next_cycle; rd_req = 1'b0;          // c1 POP
        next_cycle;                          // c2 CONV
        next_cycle; rd_req = 1'b1;           // c3 WAIT
        next_cycle; rd_req = 1'b0;           // c4 WAIT
        mid;
        chk("wait rd_err", 32'(rd_err), 32'h1);
        chk("wait busy", 32'(busy), 32'h1);
        chk("wait fifo_rd", 32'(fifo_rd), 32'h0);
        next_cycle; cvt_done = 1'b1;         // c5
        mid;
        chk("wait rd_err clr", 32'(rd_err), 32'h0);
        next_cycle; cvt_done = 1'b0;         // c6
        mid;
        chk("wait disp_val", 32'(disp_val), 32'h2A);
        chk("wait busy idle", 32'(busy), 32'h0);

        // Timeout with concurrent writes from requester 1
        next_cycle;
        fifo_rd_data = 8'h77; rd_req = 1'b1; req1 = 1'b1; data1 = 8'h5A;
        for (int c = 0; c <= 67; c++) begin
            if (c > 0) begin
                next_cycle;
                rd_req = 1'b0;
            end
            mid;
            chk($sformatf("to c%0d gnt1", c), 32'(gnt1), 32'h1);
            chk($sformatf("to c%0d wr_data", c), 32'(fifo_wr_data), 32'h5A);
            chk($sformatf("to c%0d rd_err", c), 32'(rd_err), 32'(c == 67));
            if (c == 2) chk("to c2 cvt_start", 32'(cvt_start), 32'h1);
            if (c == 66) chk("to c66 busy", 32'(busy), 32'h1);
        end
        chk("to busy", 32'(busy), 32'h0);
        chk("to disp_val", 32'(disp_val), 32'h2A);
        chk("to disp_valid", 32'(disp_valid), 32'h1);

        // Leave pointer at last=0, then reset mid-WAIT
        next_cycle; req1 = 1'b0; req0 = 1'b1; data0 = 8'h44;
        mid;
        chk("pre gnt0", 32'(gnt0), 32'h1);
        next_cycle; req0 = 1'b0; fifo_rd_data = 8'h55; rd_req = 1'b1;
        next_cycle; rd_req = 1'b0;           // POP
        next_cycle;                          // CONV
        next_cycle;                          // WAIT
        next_cycle;                          // WAIT
        mid;
        chk("mid busy", 32'(busy), 32'h1);
        chk("mid disp_val", 32'(disp_val), 32'h2A);
        #1 reset = 1'b1;
        #1;
        chk_regs_zero("async rst");
        next_cycle;
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
        mid;
        chk("post rst gnt0", 32'(gnt0), 32'h1);
        chk("post rst gnt1", 32'(gnt1), 32'h0);
        chk("post rst wr_data", 32'(fifo_wr_data), 32'h11);
        chk("post rst busy", 32'(busy), 32'h0);
        next_cycle; req0 = 1'b0; req1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
